// File: rtl/four_way_rr_merge_pkg.sv
// Shared types and the rotating-priority helper for the four-source merger.
// Also usable by any other 4-way round-robin arbiter.
package four_way_rr_merge_pkg;

  localparam int NUM_SRC   = 4;
  localparam int SRC_IDX_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } merge_state_e;

  typedef struct packed {
    logic                 any;
    logic [NUM_SRC-1:0]   gnt;
    logic [SRC_IDX_W-1:0] idx;
  } rr_pick_t;

  // Highest priority is last+1; last itself is searched last.
  function automatic rr_pick_t rr_pick(
    input logic [NUM_SRC-1:0]   req,
    input logic [SRC_IDX_W-1:0] last
  );
    rr_pick_t             r;
    logic [SRC_IDX_W-1:0] c;
    r = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      c = last + SRC_IDX_W'(k);
      if (req[c]) begin
        r.any = 1'b1;
        r.idx = c;
      end
    end
    r.gnt = r.any ? (NUM_SRC'(1) << r.idx) : '0;
    return r;
  endfunction

endpackage

// File: rtl/four_way_rr_merge_if.sv
// Source and sink stream bundle of the merger.
// slave is the merger side, master the surrounding logic.
interface four_way_rr_merge_if
  import four_way_rr_merge_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic [NUM_SRC-1:0]             in_valid;
  logic [NUM_SRC-1:0][DATA_W-1:0] in_data;
  logic [NUM_SRC-1:0]             in_last;
  logic [NUM_SRC-1:0]             in_ready;
  logic                           out_valid;
  logic [DATA_W-1:0]              out_data;
  logic                           out_last;
  logic [SRC_IDX_W-1:0]           out_src;
  logic                           out_ready;
  logic                           busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last,
    input  out_src, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last,
    output out_src, busy
  );

endinterface

// File: rtl/four_way_rr_merge_rr_pick4.sv
// Combinational rotating priority encoder over four requests.
// Grant is one-hot; idx is its binary index, any flags a grant.
module rr_pick4
  import four_way_rr_merge_pkg::*;
(
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [SRC_IDX_W-1:0] last_i,
  output logic [NUM_SRC-1:0]   gnt_o,
  output logic [SRC_IDX_W-1:0] idx_o,
  output logic                 any_o
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(req_i, last_i);
    gnt_o = pick.gnt;
    idx_o = pick.idx;
    any_o = pick.any;
  end

endmodule

// File: rtl/four_way_rr_merge.sv
// Four-source round-robin stream merger with burst lock.
// One registered output stage tagged with the source index.
module four_way_rr_merge
  import four_way_rr_merge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst_n,
  four_way_rr_merge_if.slave bus
);

  merge_state_e         state_q, state_d;
  logic [SRC_IDX_W-1:0] lock_src_q, lock_src_d;
  logic [SRC_IDX_W-1:0] last_grant_q, last_grant_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [SRC_IDX_W-1:0] out_src_q, out_src_d;

  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   gnt;
  logic [SRC_IDX_W-1:0] gnt_idx;
  logic                 gnt_any;
  logic                 load_en;
  logic                 accept;
  logic                 beat_last;

  // While locked only the burst owner may compete.
  always_comb begin
    req = bus.in_valid;
    if (state_q == LOCKED) begin
      req = bus.in_valid & (NUM_SRC'(1) << lock_src_q);
    end
  end

  rr_pick4 u_pick (
    .req_i  (req),
    .last_i (last_grant_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  assign load_en   = !out_valid_q || bus.out_ready;
  assign accept    = gnt_any && load_en;
  assign beat_last = bus.in_last[gnt_idx];

  assign bus.in_ready  = accept ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = (state_q == LOCKED);

  always_comb begin
    state_d      = state_q;
    lock_src_d   = lock_src_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_src_d    = out_src_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = gnt_idx;
          if (!beat_last) begin
            state_d    = LOCKED;
            lock_src_d = gnt_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && beat_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[gnt_idx];
      out_last_d  = beat_last;
      out_src_d   = gnt_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lock_src_q   <= '0;
      last_grant_q <= SRC_IDX_W'(NUM_SRC - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      lock_src_q   <= lock_src_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_src_q    <= out_src_d;
    end
  end

  a_onehot_ready: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(bus.in_ready));

  a_out_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    out_valid_q && !bus.out_ready |=>
      $stable({out_data_q, out_last_q, out_src_q}));

  a_busy_state: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.busy == (state_q == LOCKED));

endmodule

// File: tb/tb_four_way_rr_merge.sv
// Randomized and directed bench for four_way_rr_merge.
// Reference model tracks arbitration and the output slot behaviourally.
module tb_four_way_rr_merge;

  logic clk;
  logic rst_n;

  four_way_rr_merge_if #(.DATA_W(32)) bus ();

  four_way_rr_merge #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_lock;
  int          m_lsrc;
  int          m_lg;
  bit          m_ov;
  logic [31:0] m_data;
  bit          m_last;
  int          m_src;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0;
    m_lsrc = 0;
    m_lg   = 3;
    m_ov   = 0;
    m_data = '0;
    m_last = 0;
    m_src  = 0;
  endtask

  task automatic check_out(input string t);
    chk({t, "_ov"},   64'(bus.out_valid), 64'(m_ov));
    chk({t, "_busy"}, 64'(bus.busy),      64'(m_lock));
    chk({t, "_data"}, 64'(bus.out_data),  64'(m_data));
    chk({t, "_last"}, 64'(bus.out_last),  64'(m_last));
    chk({t, "_src"},  64'(bus.out_src),   64'(m_src));
  endtask

  // One clock: check registered outputs, drive inputs, check in_ready,
  // then advance the model to what the next edge should produce.
  task automatic drive_cycle(input logic [3:0] v, input logic [3:0] l,
                             input logic ordy, input logic [31:0] base);
    int   g;
    bit   le;
    logic [3:0] exp_rdy;
    @(negedge clk);
    check_out("cyc");
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = ordy;
    for (int i = 0; i < 4; i++) bus.in_data[i] = base + 32'(i);
    #1;
    g = -1;
    if (m_lock) begin
      if (v[m_lsrc]) g = m_lsrc;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_lg + k) % 4;
        if (g < 0 && v[c]) g = c;
      end
    end
    le      = !m_ov || ordy;
    exp_rdy = (g >= 0 && le) ? 4'(1 << g) : 4'b0000;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (g >= 0 && le) begin
      m_ov   = 1;
      m_data = base + 32'(g);
      m_last = l[g];
      m_src  = g;
      if (m_lock) begin
        if (l[g]) m_lock = 0;
      end else begin
        m_lg = g;
        if (!l[g]) begin
          m_lock = 1;
          m_lsrc = g;
        end
      end
    end else if (ordy) begin
      m_ov = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ov",   64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy),      64'(0));
    chk("rst_data", 64'(bus.out_data),  64'(0));
    chk("rst_src",  64'(bus.out_src),   64'(0));
    chk("rst_last", 64'(bus.out_last),  64'(0));
    model_reset();
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    do_reset();

    // Single beat from source 2
    drive_cycle(4'b0100, 4'b0100, 1'b1, 32'hA5A5_0000);
    chk("t1_rdy", 64'(bus.in_ready), 64'(4'b0100));
    @(posedge clk); #1;
    chk("t1_ov",   64'(bus.out_valid), 64'(1));
    chk("t1_data", 64'(bus.out_data),  64'(32'hA5A5_0002));
    chk("t1_src",  64'(bus.out_src),   64'(2));
    chk("t1_last", 64'(bus.out_last),  64'(1));
    chk("t1_busy", 64'(bus.busy),      64'(0));
    drive_cycle(4'b0000, 4'b0000, 1'b1, 32'h0);

    // Rotation from a fresh reset
    @(posedge clk); #2;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive_cycle(4'b1111, 4'b1111, 1'b1, $urandom);
      @(posedge clk); #1;
      chk("t2_src", 64'(bus.out_src), 64'(k % 4));
      chk("t2_ov",  64'(bus.out_valid), 64'(1));
    end
    drive_cycle(4'b0000, 4'b0000, 1'b1, 32'h0);

    // Source 1 burst against a continuously requesting source 0
    drive_cycle(4'b0010, 4'b0000, 1'b1, 32'h1000_0000);
    @(posedge clk); #1;
    chk("t3_busy1", 64'(bus.busy), 64'(1));
    drive_cycle(4'b0011, 4'b0000, 1'b1, 32'h1000_0100);
    chk("t3_rdy0a", 64'(bus.in_ready[0]), 64'(0));
    drive_cycle(4'b0011, 4'b0010, 1'b1, 32'h1000_0200);
    chk("t3_rdy0b", 64'(bus.in_ready[0]), 64'(0));
    @(posedge clk); #1;
    chk("t3_busy0", 64'(bus.busy), 64'(0));
    drive_cycle(4'b0001, 4'b0001, 1'b1, 32'h1000_0300);
    drive_cycle(4'b0000, 4'b0000, 1'b1, 32'h0);

    // Backpressure with sources 0 and 3
    for (int k = 0; k < 4; k++) begin
      drive_cycle(4'b1001, 4'b1001, 1'b0, 32'h2000_0000 + 32'(k << 8));
      if (k > 0) chk("t4_rdy", 64'(bus.in_ready), 64'(0));
    end
    for (int k = 0; k < 3; k++)
      drive_cycle(4'b1001, 4'b1001, 1'b1, 32'h2100_0000 + 32'(k << 8));
    drive_cycle(4'b0000, 4'b0000, 1'b1, 32'h0);

    // Source 3 burst with a gap; source 0 must wait
    drive_cycle(4'b1000, 4'b0000, 1'b1, 32'h3000_0000);
    drive_cycle(4'b0001, 4'b0001, 1'b1, 32'h3000_0100);
    chk("t5_gap1", 64'(bus.in_ready), 64'(0));
    drive_cycle(4'b0001, 4'b0001, 1'b1, 32'h3000_0200);
    chk("t5_gap2", 64'(bus.in_ready), 64'(0));
    drive_cycle(4'b1001, 4'b1000, 1'b1, 32'h3000_0300);
    chk("t5_end", 64'(bus.in_ready), 64'(4'b1000));
    drive_cycle(4'b0001, 4'b0001, 1'b1, 32'h3000_0400);
    drive_cycle(4'b0000, 4'b0000, 1'b1, 32'h0);

    // Reset mid-burst with a held output beat
    drive_cycle(4'b0100, 4'b0000, 1'b0, 32'h4000_0000);
    drive_cycle(4'b0100, 4'b0000, 1'b0, 32'h4000_0100);
    @(posedge clk); #2;
    chk("t6_pre_ov",   64'(bus.out_valid), 64'(1));
    chk("t6_pre_busy", 64'(bus.busy),      64'(1));
    do_reset();
    drive_cycle(4'b1111, 4'b1111, 1'b1, 32'h5000_0000);
    @(posedge clk); #1;
    chk("t6_src", 64'(bus.out_src), 64'(0));

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic [3:0] v;
      logic [3:0] l;
      v = 4'($urandom);
      l = 4'($urandom & $urandom);
      drive_cycle(v, l, ($urandom_range(0, 3) != 0), $urandom);
    end
    drive_cycle(4'b0000, 4'b0000, 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
